// File: rtl/ascon_pack.sv
`default_nettype none
// ============================================================================
//  Module   : ascon_pack
//  Purpose  : Shared types and round-limit constants for the ASCON
//             permutation controller.
//  Revision : 1.0  initial release
// ============================================================================
package ascon_pack;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } ctrl_state_e;

  localparam logic [3:0] ROUND_P12_START = 4'd0;
  localparam logic [3:0] ROUND_P6_START  = 4'd6;
  localparam logic [3:0] ROUND_LAST      = 4'd11;

  // First round index of a run: mode 0 = p12, mode 1 = p6
  function automatic logic [3:0] start_round(input logic mode);
    return mode ? ROUND_P6_START : ROUND_P12_START;
  endfunction

endpackage
`default_nettype wire

// File: rtl/permutation_ctrl_round_counter.sv
`default_nettype none
// ============================================================================
//  Module   : round_counter
//  Purpose  : 4-bit round index counter with synchronous load and increment
//             enable; load has priority over increment.
//  Revision : 1.0  initial release
// ============================================================================
module round_counter (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       inc_i,
  output logic [3:0] count_o
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  // Next count: load wins, otherwise optional increment
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i) begin
      count_d = count_q + 4'd1;
    end
  end

  // Count register, cleared asynchronously
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/permutation_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : permutation_ctrl
//  Purpose  : Moore controller sequencing p12 / p6 ASCON permutation rounds
//             over an external round datapath and its state register.
//  Revision : 1.0  initial release
// ============================================================================
module permutation_ctrl
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       mode_i,
  output logic       ready_o,
  output logic [3:0] round_o,
  output logic       input_select_o,
  output logic       ena_reg_state_o,
  output logic       busy_o,
  output logic       done_o
);

  ctrl_state_e state_q;
  ctrl_state_e state_d;
  logic        mode_q;
  logic        mode_d;
  logic        cnt_load;
  logic        cnt_inc;
  logic [3:0]  cnt_load_val;
  logic [3:0]  cnt_q;

  // Start round is chosen from the mode presented with the accepted start
  assign cnt_load_val = start_round(mode_i);

  round_counter u_round_counter (
    .clock_i    (clock_i),
    .resetb_i   (resetb_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .inc_i      (cnt_inc),
    .count_o    (cnt_q)
  );

  // Next-state, counter control and Moore output decode
  always_comb begin
    state_d         = state_q;
    mode_d          = mode_q;
    cnt_load        = 1'b0;
    cnt_inc         = 1'b0;
    ready_o         = 1'b0;
    round_o         = 4'd0;
    input_select_o  = 1'b0;
    ena_reg_state_o = 1'b0;
    busy_o          = 1'b0;
    done_o          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (start_i) begin
          state_d  = ST_FIRST;
          mode_d   = mode_i;
          cnt_load = 1'b1;
        end
      end
      ST_FIRST: begin
        // Datapath consumes the external state on the first round
        round_o         = start_round(mode_q);
        ena_reg_state_o = 1'b1;
        busy_o          = 1'b1;
        cnt_inc         = 1'b1;
        state_d         = ST_ROUND;
      end
      ST_ROUND: begin
        round_o         = cnt_q;
        input_select_o  = 1'b1;
        ena_reg_state_o = 1'b1;
        busy_o          = 1'b1;
        // Counter parks on the last round so it never wraps
        if (cnt_q == ROUND_LAST) begin
          state_d = ST_DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_DONE: begin
        round_o        = cnt_q;
        input_select_o = 1'b1;
        done_o         = 1'b1;
        state_d        = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched mode registers, cleared asynchronously
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_permutation_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_permutation_ctrl
//  Purpose  : Self-checking bench for permutation_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_permutation_ctrl;

  logic       clock_i  = 1'b0;
  logic       resetb_i = 1'b0;
  logic       start_i  = 1'b0;
  logic       mode_i   = 1'b0;
  logic       ready_o;
  logic [3:0] round_o;
  logic       input_select_o;
  logic       ena_reg_state_o;
  logic       busy_o;
  logic       done_o;

  int n_tests = 0;
  int n_fail  = 0;

  permutation_ctrl dut (
    .clock_i         (clock_i),
    .resetb_i        (resetb_i),
    .start_i         (start_i),
    .mode_i          (mode_i),
    .ready_o         (ready_o),
    .round_o         (round_o),
    .input_select_o  (input_select_o),
    .ena_reg_state_o (ena_reg_state_o),
    .busy_o          (busy_o),
    .done_o          (done_o)
  );

  always #5 clock_i = ~clock_i;

  // Output bundle: {ready, round[3:0], input_select, ena, busy, done}
  function automatic logic [8:0] o(input logic r, input logic [3:0] rnd,
                                   input logic sel, input logic en,
                                   input logic bsy, input logic dn);
    return {r, rnd, sel, en, bsy, dn};
  endfunction

  function automatic logic [8:0] outs();
    return {ready_o, round_o, input_select_o, ena_reg_state_o, busy_o, done_o};
  endfunction

  localparam logic [8:0] IDLE_O = 9'b1_0000_0000;

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (ready,round,sel,ena,busy,done)", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  // Mutual-exclusion invariants checked every cycle outside reset
  always @(negedge clock_i) begin
    if (resetb_i) begin
      n_tests++;
      if ((busy_o && done_o) || (ready_o && ena_reg_state_o)) begin
        n_fail++;
        $display("FAIL invariant: busy=%b done=%b ready=%b ena=%b required no overlap",
                 busy_o, done_o, ready_o, ena_reg_state_o);
      end
    end
  end

  // One complete run from IDLE, optionally holding start and toggling mode
  task automatic run_check(input logic md, input logic hold, input logic tog);
    int         n;
    logic [3:0] first;
    n     = md ? 6 : 12;
    first = md ? 4'd6 : 4'd0;
    chk("run_idle", outs(), IDLE_O);
    start_i = 1'b1;
    mode_i  = md;
    step();
    if (!hold) start_i = 1'b0;
    for (int k = 0; k < n; k++) begin
      chk("run_round", outs(), o(1'b0, 4'(first + 4'(k)), (k != 0), 1'b1, 1'b1, 1'b0));
      if (tog) mode_i = ~mode_i;
      step();
    end
    chk("run_done", outs(), o(1'b0, 4'd11, 1'b1, 1'b0, 1'b0, 1'b1));
    step();
    chk("run_ready", outs(), IDLE_O);
    start_i = 1'b0;
    mode_i  = 1'b0;
    step();
    chk("run_settle", outs(), IDLE_O);
  endtask

  typedef struct {
    logic       start;
    logic       mode;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int done_cnt;
    int ready_cnt;
    int bad;
    int i;
    int done_pos [$];

    // p6 run, with a start request during DONE that must be ignored
    tbl[0] = '{1'b1, 1'b1, o(1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[1] = '{1'b0, 1'b0, o(1'b0, 4'd6,  1'b0, 1'b1, 1'b1, 1'b0)};
    tbl[2] = '{1'b0, 1'b1, o(1'b0, 4'd7,  1'b1, 1'b1, 1'b1, 1'b0)};
    tbl[3] = '{1'b0, 1'b0, o(1'b0, 4'd8,  1'b1, 1'b1, 1'b1, 1'b0)};
    tbl[4] = '{1'b1, 1'b0, o(1'b0, 4'd9,  1'b1, 1'b1, 1'b1, 1'b0)};
    tbl[5] = '{1'b0, 1'b0, o(1'b0, 4'd10, 1'b1, 1'b1, 1'b1, 1'b0)};
    tbl[6] = '{1'b0, 1'b0, o(1'b0, 4'd11, 1'b1, 1'b1, 1'b1, 1'b0)};
    tbl[7] = '{1'b1, 1'b0, o(1'b0, 4'd11, 1'b1, 1'b0, 1'b0, 1'b1)};
    tbl[8] = '{1'b0, 1'b0, o(1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[9] = '{1'b0, 1'b0, o(1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0)};

    // Reset values
    step();
    step();
    chk("reset_held", outs(), IDLE_O);
    resetb_i = 1'b1;
    step();
    chk("reset_release", outs(), IDLE_O);

    // Table-driven p6 run
    for (int v = 0; v < 10; v++) begin
      start_i = tbl[v].start;
      mode_i  = tbl[v].mode;
      chk($sformatf("p6_vec%0d", v), outs(), tbl[v].exp);
      step();
    end
    start_i = 1'b0;
    mode_i  = 1'b0;

    // Plain p12, p12 with start held and mode toggled, plain p6
    run_check(1'b0, 1'b0, 1'b0);
    run_check(1'b0, 1'b1, 1'b1);
    run_check(1'b1, 1'b0, 1'b0);

    // Back-to-back p12 runs with start held: period DONE + one IDLE = 14 cycles
    start_i   = 1'b1;
    mode_i    = 1'b0;
    done_cnt  = 0;
    ready_cnt = 0;
    for (int c = 0; c < 42; c++) begin
      if (done_o) begin
        done_cnt++;
        done_pos.push_back(c);
      end
      if (ready_o) ready_cnt++;
      step();
    end
    start_i = 1'b0;
    chk("b2b_done_count", 9'(done_cnt), 9'd3);
    chk("b2b_ready_count", 9'(ready_cnt), 9'd3);
    for (int p = 0; p < done_pos.size() && p < 3; p++) begin
      chk($sformatf("b2b_done_pos%0d", p), 9'(done_pos[p]), 9'(13 + 14 * p));
    end
    // Let the run started at the last IDLE cycle finish
    for (int c = 0; c < 16 && !ready_o; c++) step();
    step();
    chk("b2b_back_idle", outs(), IDLE_O);

    // Asynchronous reset in the middle of a p12 run
    start_i = 1'b1;
    mode_i  = 1'b0;
    step();
    start_i = 1'b0;
    i = 0;
    while (round_o != 4'd5 && i < 20) begin
      step();
      i++;
    end
    chk("rst_reach_round5", outs(), o(1'b0, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0));
    #2 resetb_i = 1'b0;
    #1;
    chk("rst_async", outs(), IDLE_O);
    step();
    resetb_i = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (done_o || !ready_o || ena_reg_state_o) bad++;
      step();
    end
    chk("rst_no_done_after", 9'(bad), 9'd0);

    // Fresh start after reset produces a normal p6 run
    run_check(1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
